// File: rtl/alu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_ctrl_pkg
// Desc     : ALU control encoding and execution-unit state, shared with the
//            ALU control decoder so both ends agree on the code points.
// Revision : 1.0 - initial release
// ============================================================================
package alu_ctrl_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_XOR  = 4'b0001;
    localparam logic [3:0] ALU_SLL  = 4'b0010;
    localparam logic [3:0] ALU_ADD  = 4'b0011;
    localparam logic [3:0] ALU_SUB  = 4'b0100;
    localparam logic [3:0] ALU_MUL  = 4'b0101;
    localparam logic [3:0] ALU_ADDI = 4'b0110;
    localparam logic [3:0] ALU_SRAI = 4'b0111;
    localparam logic [3:0] ALU_LW   = 4'b1000;
    localparam logic [3:0] ALU_SW   = 4'b1001;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        MUL_BUSY = 1'b1
    } alu_state_e;

endpackage : alu_ctrl_pkg
`default_nettype wire

// File: rtl/alu_mul_iter.sv
`default_nettype none
// ============================================================================
// Module   : alu_mul_iter
// Desc     : Iterative shift-add multiplier retiring MUL_BITS multiplier bits
//            per cycle; returns the low DATA_W bits of the product.
// Revision : 1.0 - initial release
// ============================================================================
module alu_mul_iter #(
    parameter int DATA_W   = 32,
    parameter int MUL_BITS = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              kill_i,
    input  logic [DATA_W-1:0] op_a_i,
    input  logic [DATA_W-1:0] op_b_i,
    output logic              done_o,
    output logic [DATA_W-1:0] product_o
);

    localparam int STEPS = DATA_W / MUL_BITS;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

    logic [DATA_W-1:0] mcand_q, mcand_d;
    logic [DATA_W-1:0] mplier_q, mplier_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic [DATA_W-1:0] acc_sum;

    // Accumulator after adding this cycle's MUL_BITS partial products.
    always_comb begin
        acc_sum = acc_q;
        for (int i = 0; i < MUL_BITS; i++) begin
            if (mplier_q[i]) begin
                acc_sum = acc_sum + (mcand_q << i);
            end
        end
    end

    assign done_o    = busy_q && (cnt_q == '0);
    assign product_o = acc_sum;

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        if (start_i) begin
            mcand_d  = op_a_i;
            mplier_d = op_b_i;
            acc_d    = '0;
            cnt_d    = CNT_W'(STEPS - 1);
            busy_d   = 1'b1;
        end else if (busy_q) begin
            if (kill_i || (cnt_q == '0)) begin
                busy_d = 1'b0;
            end else begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << MUL_BITS;
                mplier_d = mplier_q >> MUL_BITS;
                cnt_d    = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
        end
    end

endmodule : alu_mul_iter
`default_nettype wire

// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_unit
// Desc     : EX-stage execution unit with registered result and valid/ready
//            handshake. Define ALU_MUL_FAST_EN for a single-cycle '*' MUL;
//            otherwise MUL uses the iterative alu_mul_iter and stalls ready_o.
// Revision : 1.0 - initial release
// ============================================================================
module alu_exec_unit
    import alu_ctrl_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int MUL_BITS = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [3:0]        ctrl_i,
    input  logic [DATA_W-1:0] op_a_i,
    input  logic [DATA_W-1:0] op_b_i,
    input  logic              kill_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] result_o,
    output logic              zero_o,
    output logic              illegal_o
);

    localparam int SH_W = $clog2(DATA_W);

    logic [DATA_W-1:0] result_q, result_d;
    logic              valid_q, valid_d;
    logic              illegal_q, illegal_d;
    logic [DATA_W-1:0] op_res;
    logic              op_illegal;
    logic [SH_W-1:0]   shamt;
    logic              accept;

    assign shamt  = op_b_i[SH_W-1:0];
    assign accept = valid_i & ready_o & ~kill_i;

    always_comb begin
        op_res     = '0;
        op_illegal = 1'b0;
        case (ctrl_i)
            ALU_AND:  op_res = op_a_i & op_b_i;
            ALU_XOR:  op_res = op_a_i ^ op_b_i;
            ALU_SLL:  op_res = op_a_i << shamt;
            ALU_ADD, ALU_ADDI, ALU_LW, ALU_SW:
                      op_res = op_a_i + op_b_i;
            ALU_SUB:  op_res = op_a_i - op_b_i;
            ALU_SRAI: op_res = $unsigned($signed(op_a_i) >>> shamt);
`ifdef ALU_MUL_FAST_EN
            ALU_MUL:  op_res = op_a_i * op_b_i;
`else
            ALU_MUL:  op_res = '0;
`endif
            default:  op_illegal = 1'b1;
        endcase
    end

`ifndef ALU_MUL_FAST_EN
    alu_state_e        state_q, state_d;
    logic              mul_start;
    logic              mul_done;
    logic [DATA_W-1:0] mul_product;

    assign ready_o = (state_q == IDLE);

    alu_mul_iter #(
        .DATA_W   (DATA_W),
        .MUL_BITS (MUL_BITS)
    ) u_mul (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (mul_start),
        .kill_i    (kill_i),
        .op_a_i    (op_a_i),
        .op_b_i    (op_b_i),
        .done_o    (mul_done),
        .product_o (mul_product)
    );

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        valid_d   = 1'b0;
        illegal_d = 1'b0;
        mul_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (ctrl_i == ALU_MUL) begin
                        mul_start = 1'b1;
                        state_d   = MUL_BUSY;
                    end else begin
                        result_d  = op_res;
                        valid_d   = 1'b1;
                        illegal_d = op_illegal;
                    end
                end
            end
            MUL_BUSY: begin
                // A flush wins over a completion landing in the same cycle.
                if (kill_i) begin
                    state_d = IDLE;
                end else if (mul_done) begin
                    result_d = mul_product;
                    valid_d  = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end
`else
    assign ready_o = 1'b1;

    always_comb begin
        result_d  = result_q;
        valid_d   = 1'b0;
        illegal_d = 1'b0;
        if (accept) begin
            result_d  = op_res;
            valid_d   = 1'b1;
            illegal_d = op_illegal;
        end
    end
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            result_q  <= '0;
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            result_q  <= result_d;
            valid_q   <= valid_d;
            illegal_q <= illegal_d;
        end
    end

    assign valid_o   = valid_q;
    assign result_o  = result_q;
    assign illegal_o = illegal_q;
    assign zero_o    = (result_q == '0);

endmodule : alu_exec_unit
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_exec_unit
// Desc     : Directed-vector scoreboard bench for alu_exec_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_exec_unit;

`ifdef ALU_MUL_FAST_EN
    localparam int EXP_BUSY = 0;
`else
    localparam int EXP_BUSY = 8;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [3:0]  ctrl_i = 4'b0;
    logic [31:0] op_a_i = '0;
    logic [31:0] op_b_i = '0;
    logic        kill_i = 1'b0;
    logic        valid_o;
    logic [31:0] result_o;
    logic        zero_o;
    logic        illegal_o;

    int checks = 0;
    int errors = 0;
    logic [32:0] exp_q[$];

    alu_exec_unit #(.DATA_W(32), .MUL_BITS(4)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .ctrl_i    (ctrl_i),
        .op_a_i    (op_a_i),
        .op_b_i    (op_b_i),
        .kill_i    (kill_i),
        .valid_o   (valid_o),
        .result_o  (result_o),
        .zero_o    (zero_o),
        .illegal_o (illegal_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic drive(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic k);
        valid_i = 1'b1;
        ctrl_i  = c;
        op_a_i  = a;
        op_b_i  = b;
        kill_i  = k;
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        kill_i  = 1'b0;
    endtask

    task automatic push(input logic [31:0] r, input logic ill);
        exp_q.push_back({ill, r});
    endtask

    // Issues a MUL, holds junk valid_i while busy, measures ready_o low cycles.
    task automatic mul_run(input logic [31:0] a, input logic [31:0] b, input logic [31:0] r,
                           input string name);
        int lowcnt = 0;
        int guard  = 0;
        push(r, 1'b0);
        drive(4'b0101, a, b, 1'b0);
        while (!valid_o && guard < 40) begin
            if (!ready_o) lowcnt++;
            valid_i = 1'b1;
            ctrl_i  = 4'b0011;
            op_a_i  = 32'h1111_1111;
            op_b_i  = 32'h2222_2222;
            @(posedge clk_i);
            #1;
            guard++;
        end
        valid_i = 1'b0;
        chk({name, "_timeout"}, 32'(guard >= 40), 32'd0);
        chk({name, "_busy_cycles"}, 32'(lowcnt), 32'(EXP_BUSY));
        chk({name, "_ready_at_valid"}, {31'd0, ready_o}, 32'd1);
    endtask

    // Monitor: every valid_o pulse is matched against the scoreboard head.
    initial begin
        logic [32:0] e;
        forever begin
            @(negedge clk_i);
            if (valid_o) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", result_o, 32'hDEAD_BEEF);
                end else begin
                    e = exp_q.pop_front();
                    chk("result", result_o, e[31:0]);
                    chk("illegal", {31'd0, illegal_o}, {31'd0, e[32]});
                    chk("zero", {31'd0, zero_o}, {31'd0, (e[31:0] == 32'd0)});
                end
            end else if (illegal_o) begin
                chk("illegal_without_valid", {31'd0, illegal_o}, 32'd0);
            end
        end
    end

    initial begin
        logic [31:0] hold;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_ready", {31'd0, ready_o}, 32'd1);
        chk("rst_valid", {31'd0, valid_o}, 32'd0);
        chk("rst_result", result_o, 32'd0);
        chk("rst_zero", {31'd0, zero_o}, 32'd1);
        chk("rst_illegal", {31'd0, illegal_o}, 32'd0);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;

        // ADD overflow wraps into the sign bit
        push(32'h8000_0000, 1'b0);
        drive(4'b0011, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        chk("add_latency", {31'd0, valid_o}, 32'd1);

        // back-to-back SUB then XOR
        push(32'h0000_0000, 1'b0);
        push(32'h0000_FF00, 1'b0);
        drive(4'b0100, 32'd5, 32'd5, 1'b0);
        chk("b2b_first_valid", {31'd0, valid_o}, 32'd1);
        drive(4'b0001, 32'h0000_F0F0, 32'h0000_0FF0, 1'b0);
        chk("b2b_second_valid", {31'd0, valid_o}, 32'd1);

        // shifts and the remaining single-cycle codes
        push(32'hF800_0000, 1'b0);
        drive(4'b0111, 32'h8000_0000, 32'h0000_0024, 1'b0);
        push(32'h8000_0000, 1'b0);
        drive(4'b0010, 32'h0000_0001, 32'd31, 1'b0);
        push(32'h0F00_0F00, 1'b0);
        drive(4'b0000, 32'hFF00_FF00, 32'h0F0F_0F0F, 1'b0);
        push(32'h0000_0009, 1'b0);
        drive(4'b0110, 32'd10, 32'hFFFF_FFFF, 1'b0);
        push(32'h0000_1020, 1'b0);
        drive(4'b1000, 32'h0000_1000, 32'h0000_0020, 1'b0);
        push(32'h0000_1FFC, 1'b0);
        drive(4'b1001, 32'h0000_2000, 32'hFFFF_FFFC, 1'b0);

        // MUL wraps; junk valid_i during busy must be ignored
        mul_run(32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD, "mul_wrap");
        @(posedge clk_i);
        #1;

        // MUL killed in its third busy cycle
`ifdef ALU_MUL_FAST_EN
        push(32'd42, 1'b0);
        hold = 32'd42;
`else
        hold = 32'hFFFF_FFFD;
`endif
        drive(4'b0101, 32'd7, 32'd6, 1'b0);
        @(posedge clk_i);
        #1;
        @(posedge clk_i);
        #1;
        kill_i = 1'b1;
        @(posedge clk_i);
        #1;
        kill_i = 1'b0;
        chk("kill_busy_ready", {31'd0, ready_o}, 32'd1);
        chk("kill_busy_valid", {31'd0, valid_o}, 32'd0);
        chk("kill_busy_hold", result_o, hold);
        push(32'd4, 1'b0);
        drive(4'b0011, 32'd2, 32'd2, 1'b0);

        // kill in IDLE drops the op but not the previous cycle's pending result
        push(32'd2, 1'b0);
        drive(4'b0011, 32'd1, 32'd1, 1'b0);
        drive(4'b0001, 32'hAAAA_AAAA, 32'h5555_5555, 1'b1);
        chk("kill_idle_valid", {31'd0, valid_o}, 32'd0);
        chk("kill_idle_hold", result_o, 32'd2);

        // zero operand still takes full latency
        mul_run(32'h1234_5678, 32'd0, 32'd0, "mul_zero");
        @(posedge clk_i);
        #1;

        // illegal code
        push(32'd0, 1'b1);
        drive(4'b1100, 32'h1234_5678, 32'h1111_1111, 1'b0);
        push(32'd0, 1'b1);
        drive(4'b1111, 32'h0000_0001, 32'h0000_0001, 1'b0);

        // reset during MUL
        push(32'd7, 1'b0);
        drive(4'b0011, 32'd3, 32'd4, 1'b0);
`ifdef ALU_MUL_FAST_EN
        push(32'd25, 1'b0);
`endif
        drive(4'b0101, 32'd5, 32'd5, 1'b0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        chk("midrst_ready", {31'd0, ready_o}, 32'd1);
        chk("midrst_valid", {31'd0, valid_o}, 32'd0);
        chk("midrst_result", result_o, 32'd0);
        chk("midrst_zero", {31'd0, zero_o}, 32'd1);

        repeat (12) @(posedge clk_i);
        #1;
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        @(negedge clk_i);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_alu_exec_unit
`default_nettype wire
